// File: rtl/instr_seq_if.sv
// Instruction issue channel between the sequencer and the downstream datapath stage.
// A word moves on every rising edge where instr_valid and instr_ready are both high.
// While instr_valid is high and instr_ready is low, the source holds instr_out stable.
// instr_ready has no meaning while instr_valid is low.
interface instr_seq_if #(
  parameter int IW = 20
);
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr_out, output instr_valid, input instr_ready);
  modport slave  (input instr_out, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Program memory plus IDLE/RUN/DONE issue FSM feeding 20-bit instruction words
// downstream one per accepted handshake, with PC / issued-count progress outputs.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  instr_seq_if.master   ifc,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued_cnt,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] mem_q [DEPTH];

  logic          start_acc;
  logic          xfer;
  logic          last_word;
  logic [AW:0]   len_c;

  assign start_acc = start && (state_q != S_RUN);
  assign xfer      = valid_q && ifc.instr_ready;
  assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign len_c     = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;

  // Loads are blocked while running and on the edge that accepts a start.
  always_ff @(posedge clk) begin
    if (load_en && (state_q != S_RUN) && !start_acc) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d = len_c;
          pc_d  = '0;
          cnt_d = '0;
          if (len_c == '0) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end else begin
            state_d = S_RUN;
            valid_d = 1'b1;
            instr_d = mem_q[0];
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          cnt_d = cnt_q + (AW+1)'(1);
        end
        // Abort wins over the last-word transition; pc holds where it stopped.
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (xfer) begin
          if (last_word) begin
            state_d = S_DONE;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_q + AW'(1);
            instr_d = mem_q[pc_q + AW'(1)];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign ifc.instr_out   = instr_q;
  assign ifc.instr_valid = valid_q;
  assign pc              = pc_q;
  assign issued_cnt      = cnt_q;
  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: load, issue with/without back-pressure,
// length boundaries, abort, blocked loads and asynchronous reset.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pc;
  logic [AW:0]   issued_cnt;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  instr_seq_if #(.IW(IW)) bus ();

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .prog_len   (prog_len),
    .start      (start),
    .abort      (abort),
    .ifc        (bus),
    .pc         (pc),
    .issued_cnt (issued_cnt),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  logic [IW-1:0] exp_q [$];
  logic [IW-1:0] mem_model [DEPTH];
  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: record a transfer if the current inputs complete one, then clock.
  task automatic step();
    logic [IW-1:0] e;
    if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      check_eq("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("xfer_data", 32'(bus.instr_out), 32'(e));
      end
      n_xfer++;
    end
    tick();
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    mem_model[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic run_to_done(input int max_cycles);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max_cycles) begin
      step();
      k++;
    end
    check_eq("done_reached", 32'(done), 32'd1);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem_model[i]);
  endtask

  initial begin
    logic [5:0]    pat;
    logic [AW-1:0] pc_prev;
    logic [IW-1:0] in_prev;

    bus.instr_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", 32'(bus.instr_out), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_cnt", 32'(issued_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    load_word(4'd0, 20'h80421);
    load_word(4'd1, 20'h41062);
    load_word(4'd2, 20'h018A3);
    for (int i = 3; i < DEPTH; i++) load_word(AW'(i), IW'(20'h10000 + i * 20'h111));

    // Back-to-back issue of three words
    push_words(3);
    do_start(5'd3);
    check_eq("t1_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("t1_pc0", 32'(pc), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_cnt0", 32'(issued_cnt), 32'd0);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_valid_off", 32'(bus.instr_valid), 32'd0);
    check_eq("t1_cnt", 32'(issued_cnt), 32'd3);
    check_eq("t1_pc_last", 32'(pc), 32'd2);
    check_eq("t1_nxfer", 32'(n_xfer), 32'd3);

    // Back-pressure pattern 0,1,0,0,1,1
    bus.instr_ready = 1'b0;
    n_xfer = 0;
    push_words(3);
    do_start(5'd3);
    pat = 6'b110010;
    for (int i = 0; i < 6; i++) begin
      bus.instr_ready = pat[i];
      pc_prev = pc;
      in_prev = bus.instr_out;
      step();
      if (!pat[i]) begin
        check_eq("t2_pc_hold", 32'(pc), 32'(pc_prev));
        check_eq("t2_instr_hold", 32'(bus.instr_out), 32'(in_prev));
      end
    end
    check_eq("t2_nxfer", 32'(n_xfer), 32'd3);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_cnt", 32'(issued_cnt), 32'd3);

    // Zero length
    bus.instr_ready = 1'b1;
    do_start(5'd0);
    check_eq("t3_done", 32'(done), 32'd1);
    check_eq("t3_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("t3_cnt", 32'(issued_cnt), 32'd0);
    tick();
    check_eq("t3_valid_later", 32'(bus.instr_valid), 32'd0);

    // Over-long length clamps to DEPTH
    n_xfer = 0;
    push_words(DEPTH);
    do_start(5'd31);
    run_to_done(40);
    check_eq("t3_nxfer16", 32'(n_xfer), 32'd16);
    check_eq("t3_pc15", 32'(pc), 32'd15);
    check_eq("t3_cnt16", 32'(issued_cnt), 32'd16);

    // Abort at pc=1 together with a transfer
    n_xfer = 0;
    push_words(2);
    do_start(5'd3);
    step();
    check_eq("t4_pc1", 32'(pc), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("t4_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_done", 32'(done), 32'd0);
    check_eq("t4_cnt", 32'(issued_cnt), 32'd2);
    check_eq("t4_pc_hold", 32'(pc), 32'd1);
    check_eq("t4_state", 32'(dbg_state), 32'd0);

    // Load during RUN is ignored
    bus.instr_ready = 1'b0;
    push_words(3);
    do_start(5'd3);
    load_en = 1'b1; load_addr = 4'd1; load_data = 20'hFFFFF;
    step();
    load_en = 1'b0;
    bus.instr_ready = 1'b1;
    run_to_done(10);
    check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Load on the start-accept edge is ignored
    exp_q.push_back(mem_model[0]);
    prog_len = 5'd1; start = 1'b1;
    load_en = 1'b1; load_addr = 4'd0; load_data = 20'hABCDE;
    tick();
    start = 1'b0; load_en = 1'b0;
    run_to_done(5);
    do_start(5'd1);
    check_eq("t5_mem0_kept", 32'(bus.instr_out), 32'(mem_model[0]));
    exp_q.push_back(mem_model[0]);
    run_to_done(5);

    // Asynchronous reset mid-run
    exp_q.push_back(mem_model[0]);
    do_start(5'd3);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_valid_async", 32'(bus.instr_valid), 32'd0);
    check_eq("t6_pc_async", 32'(pc), 32'd0);
    check_eq("t6_cnt_async", 32'(issued_cnt), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    push_words(3);
    do_start(5'd3);
    check_eq("t6_restart_instr", 32'(bus.instr_out), 32'(mem_model[0]));
    run_to_done(10);
    check_eq("t6_cnt", 32'(issued_cnt), 32'd3);
    check_eq("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
